// File: rtl/console_detect_if.sv
// Bus between the PPU-side capture logic and the console detector.
// The master drives the sample/vblank strobes and the mode override; the slave reports results.
interface console_detect_if;
    logic       ppu_sample_valid;
    logic       ppu_sample_a13;
    logic       ppu_sample_not_a13;
    logic       vblank_pulse;
    logic [1:0] force_mode;
    logic       ground_pins;
    logic       init_done;
    logic       detect_done;
    logic       new_dendy;
    logic [1:0] region;
    logic       region_valid;

    modport master (
        output ppu_sample_valid,
        output ppu_sample_a13,
        output ppu_sample_not_a13,
        output vblank_pulse,
        output force_mode,
        input  ground_pins,
        input  init_done,
        input  detect_done,
        input  new_dendy,
        input  region,
        input  region_valid
    );

    modport slave (
        input  ppu_sample_valid,
        input  ppu_sample_a13,
        input  ppu_sample_not_a13,
        input  vblank_pulse,
        input  force_mode,
        output ground_pins,
        output init_done,
        output detect_done,
        output new_dendy,
        output region,
        output region_valid
    );
endinterface

// File: rtl/console_detect.sv
// Power-on console detector: grounds the strap pins during init, classifies classic vs new
// famiclone from A13 / /A13 sample pairs, and locks the TV region from the measured vblank period.
module console_detect #(
    parameter int unsigned INIT_CYCLES  = 15,
    parameter int unsigned SAMPLES      = 2,
    parameter int unsigned MISMATCH_MIN = 1,
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned MIN_PERIOD   = 20000,
    parameter int unsigned NTSC_MAX     = 31500,
    parameter int unsigned PAL_MAX      = 34350,
    parameter int unsigned FRAMES       = 2
) (
    input  logic             m2,
    input  logic             reset,
    console_detect_if.slave  bus
);

    localparam logic [7:0]              L_INIT_CYCLES  = 8'(INIT_CYCLES);
    localparam logic [3:0]              L_SAMPLES      = 4'(SAMPLES);
    localparam logic [4:0]              L_MISMATCH_MIN = 5'(MISMATCH_MIN);
    localparam logic [2:0]              L_FRAMES       = 3'(FRAMES);
    localparam logic [PERIOD_WIDTH-1:0] L_MIN_PERIOD   = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] L_NTSC_MAX     = PERIOD_WIDTH'(NTSC_MAX);
    localparam logic [PERIOD_WIDTH-1:0] L_PAL_MAX      = PERIOD_WIDTH'(PAL_MAX);

    typedef enum logic [1:0] {StInit, StSample, StDone} phase_e;

    phase_e                  r_phase;
    logic [7:0]              r_init_cnt;
    logic [3:0]              r_lo_cnt;
    logic [3:0]              r_hi_cnt;
    logic [4:0]              r_mis_cnt;
    logic                    r_auto_new;
    logic                    r_ground_pins;
    logic                    r_init_done;
    logic                    r_detect_done;
    logic                    r_new_dendy;

    logic [PERIOD_WIDTH-1:0] r_per_cnt;
    logic                    r_armed;
    logic [1:0]              r_prev_class;
    logic [2:0]              r_agree_cnt;
    logic [1:0]              r_region;
    logic                    r_region_valid;

    logic                    w_sample;
    logic                    w_lo_below;
    logic                    w_hi_below;
    logic [3:0]              w_lo_next;
    logic [3:0]              w_hi_next;
    logic [4:0]              w_mis_next;
    logic                    w_auto_new_next;
    logic                    w_detect_next;
    logic                    w_new_dendy_next;
    logic                    w_measure;
    logic [1:0]              w_class;
    logic [2:0]              w_agree_next;

    // ---------------- console detection ----------------
    assign w_sample   = bus.ppu_sample_valid && (r_phase == StSample);
    assign w_lo_below = r_lo_cnt < L_SAMPLES;
    assign w_hi_below = r_hi_cnt < L_SAMPLES;

    always_comb begin
        w_lo_next  = r_lo_cnt;
        w_hi_next  = r_hi_cnt;
        w_mis_next = r_mis_cnt;
        if (w_sample) begin
            if (!bus.ppu_sample_a13 && w_lo_below) w_lo_next = r_lo_cnt + 4'd1;
            if (bus.ppu_sample_a13 && w_hi_below)  w_hi_next = r_hi_cnt + 4'd1;
            // Mismatches only count while both levels are still being collected.
            if (w_lo_below && w_hi_below && (bus.ppu_sample_a13 == bus.ppu_sample_not_a13)
                && (r_mis_cnt != 5'h1f)) begin
                w_mis_next = r_mis_cnt + 5'd1;
            end
        end
    end

    assign w_auto_new_next = r_auto_new || (w_mis_next >= L_MISMATCH_MIN);
    assign w_detect_next   = (w_lo_next == L_SAMPLES) && (w_hi_next == L_SAMPLES);

    always_comb begin
        w_new_dendy_next = w_auto_new_next;
        case (bus.force_mode)
            2'b01:   w_new_dendy_next = 1'b0;
            2'b10:   w_new_dendy_next = 1'b1;
            default: w_new_dendy_next = w_auto_new_next;
        endcase
    end

    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            r_phase       <= StInit;
            r_init_cnt    <= L_INIT_CYCLES;
            r_lo_cnt      <= '0;
            r_hi_cnt      <= '0;
            r_mis_cnt     <= '0;
            r_auto_new    <= 1'b0;
            r_ground_pins <= 1'b1;
            r_init_done   <= 1'b0;
            r_detect_done <= 1'b0;
            r_new_dendy   <= 1'b0;
        end else begin
            r_new_dendy <= w_new_dendy_next;
            case (r_phase)
                StInit: begin
                    r_init_cnt <= r_init_cnt - 8'd1;
                    if (r_init_cnt == 8'd1) begin
                        r_phase       <= StSample;
                        r_init_done   <= 1'b1;
                        r_ground_pins <= 1'b0;
                    end
                end
                StSample: begin
                    r_lo_cnt   <= w_lo_next;
                    r_hi_cnt   <= w_hi_next;
                    r_mis_cnt  <= w_mis_next;
                    r_auto_new <= w_auto_new_next;
                    if (w_detect_next) begin
                        r_phase       <= StDone;
                        r_detect_done <= 1'b1;
                    end
                end
                StDone: begin
                    r_phase <= StDone;
                end
                default: begin
                    r_phase <= StInit;
                end
            endcase
        end
    end

    // ---------------- region measurement ----------------
    assign w_measure = r_init_done && bus.vblank_pulse && r_armed;

    always_comb begin
        if ((r_per_cnt == '1) || (r_per_cnt < L_MIN_PERIOD)) begin
            w_class = 2'b00;
        end else if (r_per_cnt <= L_NTSC_MAX) begin
            w_class = 2'b01;
        end else if (r_per_cnt <= L_PAL_MAX) begin
            w_class = 2'b10;
        end else begin
            w_class = 2'b11;
        end
    end

    always_comb begin
        w_agree_next = 3'd1;
        if (w_class == 2'b00) begin
            w_agree_next = 3'd0;
        end else if (w_class == r_prev_class) begin
            w_agree_next = (r_agree_cnt < L_FRAMES) ? r_agree_cnt + 3'd1 : r_agree_cnt;
        end
    end

    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            r_per_cnt      <= '0;
            r_armed        <= 1'b0;
            r_prev_class   <= 2'b00;
            r_agree_cnt    <= '0;
            r_region       <= 2'b00;
            r_region_valid <= 1'b0;
        end else if (r_init_done) begin
            if (bus.vblank_pulse) begin
                r_per_cnt <= PERIOD_WIDTH'(1);
                r_armed   <= 1'b1;
            end else if (r_per_cnt != '1) begin
                r_per_cnt <= r_per_cnt + PERIOD_WIDTH'(1);
            end
            if (w_measure) begin
                // An invalid period stores class 00 so the next valid one restarts at 1.
                r_prev_class <= w_class;
                r_agree_cnt  <= w_agree_next;
                if (w_agree_next == L_FRAMES) begin
                    r_region       <= w_class;
                    r_region_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.ground_pins  = r_ground_pins;
    assign bus.init_done    = r_init_done;
    assign bus.detect_done  = r_detect_done;
    assign bus.new_dendy    = r_new_dendy;
    assign bus.region       = r_region;
    assign bus.region_valid = r_region_valid;

endmodule
